// File: rtl/axi_lite_slave_mem_if.sv
// AXI-Lite bus bundle between the team's master and the register-file responder.
interface axi_lite_slave_mem_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rvalid
    );
endinterface

// File: rtl/axi_lite_slave_mem.sv
// AXI-Lite responder backed by a DEPTH-word register file; one outstanding read
// and one outstanding write, AW and W accepted independently.
module axi_lite_slave_mem #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  reset,
    axi_lite_slave_mem_if.slave  s_axi
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

    wstate_t     r_wstate;
    rstate_t     r_rstate;
    logic [31:0] r_mem [DEPTH];
    logic        r_aw_held, r_w_held;
    logic [31:0] r_awaddr, r_wdata;
    logic        r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]  r_bresp;
    logic [31:0] r_rdata;

    logic          w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [31:0]   w_waddr, w_wdat;
    logic [AW-1:0] w_widx, w_ridx;
    logic [1:0]    w_wresp, w_rresp;

    // Below-base addresses wrap to a large offset, so one compare covers both ends.
    function automatic logic [1:0] f_decode(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        if (off >= SPAN)
            return 2'b11;
        else if (addr[1:0] != 2'b00)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // BASE_ADDR is aligned to the window size, so the index is just the address bits.
    always_comb begin
        w_aw_hs  = s_axi.awvalid & r_awready;
        w_w_hs   = s_axi.wvalid & r_wready;
        w_ar_hs  = s_axi.arvalid & r_arready;
        w_waddr  = w_aw_hs ? s_axi.awaddr : r_awaddr;
        w_wdat   = w_w_hs ? s_axi.wdata : r_wdata;
        w_widx   = w_waddr[AW+1:2];
        w_wresp  = f_decode(w_waddr);
        w_ridx   = s_axi.araddr[AW+1:2];
        w_rresp  = f_decode(s_axi.araddr);
        w_commit = (r_wstate == W_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            for (int unsigned i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        if (w_wresp == 2'b00)
                            r_mem[w_widx] <= w_wdat;
                        r_awaddr  <= w_waddr;
                        r_wdata   <= w_wdat;
                        r_aw_held <= 1'b1;
                        r_w_held  <= 1'b1;
                        r_bresp   <= w_wresp;
                        r_bvalid  <= 1'b1;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_wstate  <= W_RESP;
                    end else begin
                        if (w_aw_hs) begin
                            r_awaddr  <= s_axi.awaddr;
                            r_aw_held <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_wdata  <= s_axi.wdata;
                            r_w_held <= 1'b1;
                        end
                        r_awready <= ~(r_aw_held | w_aw_hs);
                        r_wready  <= ~(r_w_held | w_w_hs);
                    end
                end
                W_RESP: begin
                    if (r_bvalid & s_axi.bready) begin
                        r_bvalid  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Reads see r_mem before this edge's commit, so a same-edge write returns old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata   <= (w_rresp == 2'b00) ? r_mem[w_ridx] : '0;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_rvalid & s_axi.rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
endmodule

// File: doc/axi_lite_slave_mem.md
# axi_lite_slave_mem

Memory-mapped AXI-Lite responder that terminates the five channels driven by the team's AXI master. It holds a small register file, accepts write address and write data independently and acknowledges each write on the response channel. It serves single-beat reads with one outstanding read and one outstanding write at a time. It sits at the far end of the master's bus as the default target for bring-up and integration tests.

## Interface
- DEPTH, 16: number of 32-bit words in the register file; power of two, 2..256.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to 4*DEPTH.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- awaddr  in  32  write byte address.
- awvalid  in  1  write address valid.
- awready  out  1  write address accepted.
- wdata  in  32  write data; always a full word.
- wvalid  in  1  write data valid.
- wready  out  1  write data accepted.
- bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR, 2'b11 DECERR.
- bvalid  out  1  write response valid.
- bready  in  1  master accepts the response.
- araddr  in  32  read byte address.
- arvalid  in  1  read address valid.
- arready  out  1  read address accepted.
- rdata  out  32  read data.
- rvalid  out  1  read data valid.
- rready  in  1  master accepts the read data.

## Operation
- Word index: (addr - BASE_ADDR) >> 2, using log2(DEPTH) bits.
- Decode:
  - addr outside [BASE_ADDR, BASE_ADDR + 4*DEPTH) -> DECERR.
  - in range but addr[1:0] != 0 -> SLVERR.
  - otherwise OKAY.
  - Writes with an error response do not modify memory.
  - Reads with an error response return rdata = 32'h0.
- Write FSM states W_IDLE and W_RESP.
  - In W_IDLE, awready = ~aw_held and wready = ~w_held. An AW handshake latches awaddr and sets aw_held. A W handshake latches wdata and sets w_held.
  - Either channel may arrive first, and both may arrive in the same cycle.
  - On the edge where both are held (counting handshakes on that same edge), the word is committed, bresp is loaded, bvalid is set to 1, awready and wready are cleared, and the FSM moves to W_RESP.
  - In W_RESP, bvalid and bresp stay stable until bvalid & bready. On that edge, bvalid goes to 0, the held flags clear, awready and wready go to 1, and the FSM returns to W_IDLE.
- Read FSM states R_IDLE and R_DATA.
  - In R_IDLE, arready = 1. On arvalid & arready, rdata is loaded from memory (or 0 on error), rvalid is set to 1, arready goes to 0, and the FSM moves to R_DATA.
  - In R_DATA, rdata is held stable until rvalid & rready. On that edge, rvalid goes to 0, arready goes to 1, and the FSM returns to R_IDLE.
- Read and write FSMs are independent and may be active in the same cycle.
- A read sampled on the same edge as a write commit to the same word returns the old value.

## Timing
- Reset values: awready, wready, bvalid, arready, rvalid = 0; bresp = 2'b00; rdata = 0; memory cleared to 0; FSMs in W_IDLE/R_IDLE; held flags clear.
- Assertion of reset mid-transaction:
  - Aborts the transaction immediately.
  - The pending write is discarded.
- First edge after reset release: awready, wready and arready go to 1.
- Write latency: bvalid is high one cycle after the edge on which the later of the AW and W handshakes occurs.
  - Minimum 2 cycles per write with bready tied high.
- Read latency: rvalid is high one cycle after the AR handshake.
  - Minimum 2 cycles per read with rready tied high.
- All outputs are registered. The ready signals do not depend combinationally on any valid.
- Stall of bready or rready: the response is held indefinitely, and no new address on that path is accepted.

## Test plan
- Basic write/read:
  - AW 0x8 and W 0xCAFEF00D in the same cycle -> bvalid one cycle later with bresp 00.
  - Then AR 0x8 -> rvalid the next cycle with rdata 0xCAFEF00D.
- Skewed write:
  - W 0x11 three cycles before AW 0x4 -> wready low after the W handshake, and no bvalid until AW.
  - bresp 00; a read of 0x4 returns 0x11.
- Errors (DEPTH 16, BASE 0):
  - Write 0x40 -> bresp 11, and memory is unchanged.
  - Write 0x6 -> bresp 10.
  - Read 0x40 -> rdata 0.
- Backpressure:
  - bready held low for 5 cycles -> bvalid and bresp stable, and awready/wready held low.
  - rready held low for 5 cycles -> rdata stable, and arready held low.
- Simultaneous read and write to 0xC:
  - Old value 0x1, new value 0x2 -> the read returns 0x1.
  - A later read returns 0x2.
- Reset mid-write:
  - AW accepted, W not yet sent, then reset -> all outputs 0.
  - After release, a new write and read work, and the memory reads 0.
